// File: rtl/decode_pkg.sv
// Shared definitions for the decode queue: opcode encodings, op-vector
// widths, one-hot bit positions and the decoded-bundle struct.
// One-hot vectors list their members MSB first, so csr_op[5:0] holds the
// six Zicsr register/immediate forms.
package decode_pkg;

  localparam int ALU_W = 10;
  localparam int BRU_W = 8;
  localparam int LSU_W = 7;
  localparam int CSR_W = 10;

  typedef enum logic [6:0] {
    OPC_LUI      = 7'b0110111,
    OPC_AUIPC    = 7'b0010111,
    OPC_JAL      = 7'b1101111,
    OPC_JALR     = 7'b1100111,
    OPC_BRANCH   = 7'b1100011,
    OPC_LOAD     = 7'b0000011,
    OPC_STORE    = 7'b0100011,
    OPC_OP_IMM   = 7'b0010011,
    OPC_OP_IMM32 = 7'b0011011,
    OPC_OP       = 7'b0110011,
    OPC_OP32     = 7'b0111011,
    OPC_MISC_MEM = 7'b0001111,
    OPC_SYSTEM   = 7'b1110011
  } opcode_e;

  // ALU op bits
  localparam int ALU_ADD  = 9;
  localparam int ALU_SUB  = 8;
  localparam int ALU_SLL  = 7;
  localparam int ALU_SLT  = 6;
  localparam int ALU_SLTU = 5;
  localparam int ALU_XOR  = 4;
  localparam int ALU_SRL  = 3;
  localparam int ALU_SRA  = 2;
  localparam int ALU_OR   = 1;
  localparam int ALU_AND  = 0;

  // Branch unit op bits
  localparam int BRU_JAL  = 7;
  localparam int BRU_JALR = 6;
  localparam int BRU_BEQ  = 5;
  localparam int BRU_BNE  = 4;
  localparam int BRU_BLT  = 3;
  localparam int BRU_BGE  = 2;
  localparam int BRU_BLTU = 1;
  localparam int BRU_BGEU = 0;

  // Load/store unit op bits
  localparam int LSU_EN     = 6;
  localparam int LSU_WE     = 5;
  localparam int LSU_BYTE   = 4;
  localparam int LSU_HALF   = 3;
  localparam int LSU_WORD   = 2;
  localparam int LSU_DOUBLE = 1;
  localparam int LSU_UNS    = 0;

  // System / CSR op bits
  localparam int CSR_FENCE   = 9;
  localparam int CSR_FENCE_I = 8;
  localparam int CSR_ECALL   = 7;
  localparam int CSR_EBREAK  = 6;
  localparam int CSR_CSRRW   = 5;
  localparam int CSR_CSRRS   = 4;
  localparam int CSR_CSRRC   = 3;
  localparam int CSR_CSRRWI  = 2;
  localparam int CSR_CSRRSI  = 1;
  localparam int CSR_CSRRCI  = 0;

  // Operand / result select bits
  localparam int SRC1_PC     = 1;
  localparam int SRC1_ZERO   = 0;
  localparam int RFRES_PC4   = 1;
  localparam int RFRES_LOAD  = 0;

  // Decoded bundle; the immediate is XLEN-wide and travels alongside it.
  typedef struct packed {
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [ALU_W-1:0] alu_op;
    logic             word;
    logic [BRU_W-1:0] bru_op;
    logic [LSU_W-1:0] lsu_op;
    logic [CSR_W-1:0] csr_op;
    logic [1:0]       sel_src1;
    logic             sel_src2;
    logic [1:0]       sel_rf_res;
    logic             rf_we;
    logic             illegal;
  } decoded_t;

endpackage

// File: rtl/decode_core.sv
// Combinational RV32I/RV64I instruction decoder.
// Optional feature: define ZICSR_DECODE_EN to decode the six Zicsr
// instructions; otherwise they are reported illegal.
module decode_core
  import decode_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     inst_i,
  output decoded_t        dec_o,
  output logic [XLEN-1:0] imm_o
);

  localparam bit IS64 = (XLEN == 64);

  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh6, imm_sh5;
  logic            shift_hi_ok;
  decoded_t        dec_d;
  logic [XLEN-1:0] imm_d;
  logic            legal;

  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];

  assign imm_i   = XLEN'($signed(inst_i[31:20]));
  assign imm_s   = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
  assign imm_b   = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
  assign imm_u   = XLEN'($signed({inst_i[31:12], 12'b0}));
  assign imm_j   = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));
  assign imm_sh6 = XLEN'(inst_i[25:20]);
  assign imm_sh5 = XLEN'(inst_i[24:20]);

  // shamt[5] is only meaningful for full-width shifts on a 64-bit core
  assign shift_hi_ok = IS64 || !inst_i[25];

  // Decode the instruction word into the op/select bundle and immediate
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned, which would infer a latch.
    dec_d = '0;
    imm_d = '0;
    legal = 1'b0;

    case (opcode_e'(inst_i[6:0]))
      OPC_LUI: begin
        legal = 1'b1;
        dec_d.alu_op[ALU_ADD]      = 1'b1;
        dec_d.sel_src1[SRC1_ZERO]  = 1'b1;
        dec_d.sel_src2             = 1'b1;
        dec_d.rf_we                = 1'b1;
        imm_d                      = imm_u;
      end
      OPC_AUIPC: begin
        legal = 1'b1;
        dec_d.alu_op[ALU_ADD]      = 1'b1;
        dec_d.sel_src1[SRC1_PC]    = 1'b1;
        dec_d.sel_src2             = 1'b1;
        dec_d.rf_we                = 1'b1;
        imm_d                      = imm_u;
      end
      OPC_JAL: begin
        legal = 1'b1;
        dec_d.bru_op[BRU_JAL]        = 1'b1;
        dec_d.sel_rf_res[RFRES_PC4]  = 1'b1;
        dec_d.rf_we                  = 1'b1;
        imm_d                        = imm_j;
      end
      OPC_JALR: begin
        legal = (funct3 == 3'b000);
        dec_d.bru_op[BRU_JALR]       = 1'b1;
        dec_d.sel_rf_res[RFRES_PC4]  = 1'b1;
        dec_d.rf_we                  = 1'b1;
        imm_d                        = imm_i;
      end
      OPC_BRANCH: begin
        legal = 1'b1;
        imm_d = imm_b;
        case (funct3)
          3'b000:  dec_d.bru_op[BRU_BEQ]  = 1'b1;
          3'b001:  dec_d.bru_op[BRU_BNE]  = 1'b1;
          3'b100:  dec_d.bru_op[BRU_BLT]  = 1'b1;
          3'b101:  dec_d.bru_op[BRU_BGE]  = 1'b1;
          3'b110:  dec_d.bru_op[BRU_BLTU] = 1'b1;
          3'b111:  dec_d.bru_op[BRU_BGEU] = 1'b1;
          default: legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        legal = 1'b1;
        dec_d.lsu_op[LSU_EN]          = 1'b1;
        dec_d.alu_op[ALU_ADD]         = 1'b1;
        dec_d.sel_src2                = 1'b1;
        dec_d.sel_rf_res[RFRES_LOAD]  = 1'b1;
        dec_d.rf_we                   = 1'b1;
        imm_d                         = imm_i;
        case (funct3)
          3'b000: dec_d.lsu_op[LSU_BYTE] = 1'b1;
          3'b001: dec_d.lsu_op[LSU_HALF] = 1'b1;
          3'b010: dec_d.lsu_op[LSU_WORD] = 1'b1;
          3'b011: begin
            dec_d.lsu_op[LSU_DOUBLE] = 1'b1;
            legal = IS64;
          end
          3'b100: dec_d.lsu_op[LSU_BYTE] = 1'b1;
          3'b101: dec_d.lsu_op[LSU_HALF] = 1'b1;
          3'b110: begin
            dec_d.lsu_op[LSU_WORD] = 1'b1;
            legal = IS64;
          end
          default: legal = 1'b0;
        endcase
        dec_d.lsu_op[LSU_UNS] = funct3[2];
      end
      OPC_STORE: begin
        legal = 1'b1;
        dec_d.lsu_op[LSU_EN]  = 1'b1;
        dec_d.lsu_op[LSU_WE]  = 1'b1;
        dec_d.alu_op[ALU_ADD] = 1'b1;
        dec_d.sel_src2        = 1'b1;
        imm_d                 = imm_s;
        case (funct3)
          3'b000: dec_d.lsu_op[LSU_BYTE] = 1'b1;
          3'b001: dec_d.lsu_op[LSU_HALF] = 1'b1;
          3'b010: dec_d.lsu_op[LSU_WORD] = 1'b1;
          3'b011: begin
            dec_d.lsu_op[LSU_DOUBLE] = 1'b1;
            legal = IS64;
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        legal = 1'b1;
        dec_d.sel_src2 = 1'b1;
        dec_d.rf_we    = 1'b1;
        imm_d          = imm_i;
        case (funct3)
          3'b000: dec_d.alu_op[ALU_ADD]  = 1'b1;
          3'b010: dec_d.alu_op[ALU_SLT]  = 1'b1;
          3'b011: dec_d.alu_op[ALU_SLTU] = 1'b1;
          3'b100: dec_d.alu_op[ALU_XOR]  = 1'b1;
          3'b110: dec_d.alu_op[ALU_OR]   = 1'b1;
          3'b111: dec_d.alu_op[ALU_AND]  = 1'b1;
          3'b001: begin
            dec_d.alu_op[ALU_SLL] = 1'b1;
            imm_d = IS64 ? imm_sh6 : imm_sh5;
            legal = (inst_i[31:26] == 6'b000000) && shift_hi_ok;
          end
          default: begin
            // funct3 = 101: inst[30] selects arithmetic right shift
            dec_d.alu_op[ALU_SRA] = inst_i[30];
            dec_d.alu_op[ALU_SRL] = !inst_i[30];
            imm_d = IS64 ? imm_sh6 : imm_sh5;
            legal = ({inst_i[31], inst_i[29:26]} == 5'b00000) && shift_hi_ok;
          end
        endcase
      end
      OPC_OP_IMM32: begin
        dec_d.word     = 1'b1;
        dec_d.sel_src2 = 1'b1;
        dec_d.rf_we    = 1'b1;
        imm_d          = imm_i;
        case (funct3)
          3'b000: begin
            dec_d.alu_op[ALU_ADD] = 1'b1;
            legal = IS64;
          end
          3'b001: begin
            dec_d.alu_op[ALU_SLL] = 1'b1;
            imm_d = imm_sh5;
            legal = IS64 && (funct7 == 7'b0000000);
          end
          3'b101: begin
            dec_d.alu_op[ALU_SRA] = inst_i[30];
            dec_d.alu_op[ALU_SRL] = !inst_i[30];
            imm_d = imm_sh5;
            legal = IS64 && ((funct7 == 7'b0000000) || (funct7 == 7'b0100000));
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_OP: begin
        legal = 1'b1;
        dec_d.rf_we = 1'b1;
        case ({funct7, funct3})
          {7'h00, 3'b000}: dec_d.alu_op[ALU_ADD]  = 1'b1;
          {7'h20, 3'b000}: dec_d.alu_op[ALU_SUB]  = 1'b1;
          {7'h00, 3'b001}: dec_d.alu_op[ALU_SLL]  = 1'b1;
          {7'h00, 3'b010}: dec_d.alu_op[ALU_SLT]  = 1'b1;
          {7'h00, 3'b011}: dec_d.alu_op[ALU_SLTU] = 1'b1;
          {7'h00, 3'b100}: dec_d.alu_op[ALU_XOR]  = 1'b1;
          {7'h00, 3'b101}: dec_d.alu_op[ALU_SRL]  = 1'b1;
          {7'h20, 3'b101}: dec_d.alu_op[ALU_SRA]  = 1'b1;
          {7'h00, 3'b110}: dec_d.alu_op[ALU_OR]   = 1'b1;
          {7'h00, 3'b111}: dec_d.alu_op[ALU_AND]  = 1'b1;
          default:         legal = 1'b0;
        endcase
      end
      OPC_OP32: begin
        legal = IS64;
        dec_d.word  = 1'b1;
        dec_d.rf_we = 1'b1;
        case ({funct7, funct3})
          {7'h00, 3'b000}: dec_d.alu_op[ALU_ADD] = 1'b1;
          {7'h20, 3'b000}: dec_d.alu_op[ALU_SUB] = 1'b1;
          {7'h00, 3'b001}: dec_d.alu_op[ALU_SLL] = 1'b1;
          {7'h00, 3'b101}: dec_d.alu_op[ALU_SRL] = 1'b1;
          {7'h20, 3'b101}: dec_d.alu_op[ALU_SRA] = 1'b1;
          default:         legal = 1'b0;
        endcase
      end
      OPC_MISC_MEM: begin
        case (funct3)
          3'b000: begin
            legal = 1'b1;
            dec_d.csr_op[CSR_FENCE] = 1'b1;
          end
          3'b001: begin
            legal = 1'b1;
            dec_d.csr_op[CSR_FENCE_I] = 1'b1;
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_SYSTEM: begin
        case (funct3)
          3'b000: begin
            if (inst_i[31:7] == 25'h0) begin
              legal = 1'b1;
              dec_d.csr_op[CSR_ECALL] = 1'b1;
            end else if (inst_i[31:7] == {12'h001, 13'h0}) begin
              legal = 1'b1;
              dec_d.csr_op[CSR_EBREAK] = 1'b1;
            end
          end
`ifdef ZICSR_DECODE_EN
          3'b001: begin
            legal = 1'b1;
            dec_d.rf_we = 1'b1;
            dec_d.csr_op[CSR_CSRRW] = 1'b1;
          end
          3'b010: begin
            legal = 1'b1;
            dec_d.rf_we = 1'b1;
            dec_d.csr_op[CSR_CSRRS] = 1'b1;
          end
          3'b011: begin
            legal = 1'b1;
            dec_d.rf_we = 1'b1;
            dec_d.csr_op[CSR_CSRRC] = 1'b1;
          end
          3'b101: begin
            legal = 1'b1;
            dec_d.rf_we = 1'b1;
            dec_d.csr_op[CSR_CSRRWI] = 1'b1;
            imm_d = XLEN'(inst_i[19:15]);
          end
          3'b110: begin
            legal = 1'b1;
            dec_d.rf_we = 1'b1;
            dec_d.csr_op[CSR_CSRRSI] = 1'b1;
            imm_d = XLEN'(inst_i[19:15]);
          end
          3'b111: begin
            legal = 1'b1;
            dec_d.rf_we = 1'b1;
            dec_d.csr_op[CSR_CSRRCI] = 1'b1;
            imm_d = XLEN'(inst_i[19:15]);
          end
`endif
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase

    // Unrecognised encodings carry only the illegal flag and register fields
    if (!legal) begin
      dec_d         = '0;
      imm_d         = '0;
      dec_d.illegal = 1'b1;
    end

    dec_d.rs1 = inst_i[19:15];
    dec_d.rs2 = inst_i[24:20];
    dec_d.rd  = inst_i[11:7];

    // Writes to x0 are discarded at decode time
    if (inst_i[11:7] == 5'd0) dec_d.rf_we = 1'b0;
  end

  assign dec_o = dec_d;
  assign imm_o = imm_d;

endmodule

// File: rtl/decode_queue.sv
// Decode queue: decodes at enqueue and buffers DEPTH decoded instructions
// in FIFO order; head-entry fields drive the outputs directly.
// DEPTH must be a power of two >= 2 so pointers wrap naturally.
// Optional feature: ZICSR_DECODE_EN (Zicsr decoding, see decode_core).
module decode_queue
  import decode_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_inst,
  input  logic [XLEN-1:0]         in_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_pc,
  output logic [4:0]              out_rs1,
  output logic [4:0]              out_rs2,
  output logic [4:0]              out_rd,
  output logic [XLEN-1:0]         out_imm,
  output logic [ALU_W-1:0]        out_alu_op,
  output logic                    out_word,
  output logic [BRU_W-1:0]        out_bru_op,
  output logic [LSU_W-1:0]        out_lsu_op,
  output logic [CSR_W-1:0]        out_csr_op,
  output logic [1:0]              out_sel_src1,
  output logic                    out_sel_src2,
  output logic [1:0]              out_sel_rf_res,
  output logic                    out_rf_we,
  output logic                    out_illegal,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  decoded_t         dec_mem_q [DEPTH];
  logic [XLEN-1:0]  imm_mem_q [DEPTH];
  logic [XLEN-1:0]  pc_mem_q  [DEPTH];

  decoded_t         in_dec;
  logic [XLEN-1:0]  in_imm;
  decoded_t         head;
  logic             push;
  logic             pop;

  decode_core #(
    .XLEN (XLEN)
  ) u_decode_core (
    .inst_i (in_inst),
    .dec_o  (in_dec),
    .imm_o  (in_imm)
  );

  assign in_ready  = (count_q < FULL_CNT);
  assign out_valid = (count_q != '0);
  // A flush cycle drops any offered instruction
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  // Next-state for pointers and occupancy; flush wins over traffic
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry payload storage written on enqueue
  always_ff @(posedge clk) begin
    // NOTE: payload is not reset; count gates every read, so stale contents are never visible.
    if (push) begin
      dec_mem_q[wr_ptr_q] <= in_dec;
      imm_mem_q[wr_ptr_q] <= in_imm;
      pc_mem_q[wr_ptr_q]  <= in_pc;
    end
  end

  assign head = dec_mem_q[rd_ptr_q];

  // Head entry fields, forced to zero while the queue is empty
  assign out_pc         = out_valid ? pc_mem_q[rd_ptr_q]  : '0;
  assign out_imm        = out_valid ? imm_mem_q[rd_ptr_q] : '0;
  assign out_rs1        = out_valid ? head.rs1            : '0;
  assign out_rs2        = out_valid ? head.rs2            : '0;
  assign out_rd         = out_valid ? head.rd             : '0;
  assign out_alu_op     = out_valid ? head.alu_op         : '0;
  assign out_word       = out_valid ? head.word           : 1'b0;
  assign out_bru_op     = out_valid ? head.bru_op         : '0;
  assign out_lsu_op     = out_valid ? head.lsu_op         : '0;
  assign out_csr_op     = out_valid ? head.csr_op         : '0;
  assign out_sel_src1   = out_valid ? head.sel_src1       : '0;
  assign out_sel_src2   = out_valid ? head.sel_src2       : 1'b0;
  assign out_sel_rf_res = out_valid ? head.sel_rf_res     : '0;
  assign out_rf_we      = out_valid ? head.rf_we          : 1'b0;
  assign out_illegal    = out_valid ? head.illegal        : 1'b0;
  assign count          = count_q;

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: a 64-bit and a 32-bit instance share all inputs.
// Table of decode vectors plus directed sequences for fill/wrap, flush and
// mid-operation reset. Honours ZICSR_DECODE_EN for the csrrw expectation.
module tb_decode_queue;
  import decode_pkg::*;

  localparam int DEPTH = 4;

  logic        clk, resetn, flush, in_valid, out_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;

  logic        in_ready, out_valid, out_word, out_sel_src2, out_rf_we, out_illegal;
  logic [63:0] out_pc, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [9:0]  out_alu_op, out_csr_op;
  logic [7:0]  out_bru_op;
  logic [6:0]  out_lsu_op;
  logic [1:0]  out_sel_src1, out_sel_rf_res;
  logic [2:0]  count;

  logic        s_in_ready, s_out_valid, s_word, s_sel_src2, s_rf_we, s_illegal;
  logic [31:0] s_pc, s_imm;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic [9:0]  s_alu_op, s_csr_op;
  logic [7:0]  s_bru_op;
  logic [6:0]  s_lsu_op;
  logic [1:0]  s_sel_src1, s_sel_rf_res;
  logic [2:0]  s_count;

  int total = 0;
  int bad   = 0;

  decode_queue #(.XLEN(64), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_alu_op(out_alu_op), .out_word(out_word), .out_bru_op(out_bru_op),
    .out_lsu_op(out_lsu_op), .out_csr_op(out_csr_op), .out_sel_src1(out_sel_src1),
    .out_sel_src2(out_sel_src2), .out_sel_rf_res(out_sel_rf_res),
    .out_rf_we(out_rf_we), .out_illegal(out_illegal), .count(count)
  );

  decode_queue #(.XLEN(32), .DEPTH(DEPTH)) dut32 (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_inst(in_inst), .in_pc(in_pc[31:0]),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_pc(s_pc),
    .out_rs1(s_rs1), .out_rs2(s_rs2), .out_rd(s_rd), .out_imm(s_imm),
    .out_alu_op(s_alu_op), .out_word(s_word), .out_bru_op(s_bru_op),
    .out_lsu_op(s_lsu_op), .out_csr_op(s_csr_op), .out_sel_src1(s_sel_src1),
    .out_sel_src2(s_sel_src2), .out_sel_rf_res(s_sel_rf_res),
    .out_rf_we(s_rf_we), .out_illegal(s_illegal), .count(s_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic        ill;
    logic [9:0]  alu;
    logic        word;
    logic [7:0]  bru;
    logic [6:0]  lsu;
    logic [9:0]  csr;
    logic [1:0]  src1;
    logic        src2;
    logic [1:0]  rfres;
    logic        we;
    logic [4:0]  rd;
    logic [63:0] imm;
    logic        ill32;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];
  logic [63:0] exp_q [$];

  localparam logic [9:0] A_ADD = 10'd1 << ALU_ADD;
  localparam logic [9:0] A_SUB = 10'd1 << ALU_SUB;
  localparam logic [9:0] A_SLL = 10'd1 << ALU_SLL;
  localparam logic [9:0] A_SRA = 10'd1 << ALU_SRA;

  function automatic vec_t mk(logic [31:0] inst, logic ill, logic [9:0] alu, logic word,
                              logic [7:0] bru, logic [6:0] lsu, logic [9:0] csr,
                              logic [1:0] src1, logic src2, logic [1:0] rfres, logic we,
                              logic [4:0] rd, logic [63:0] imm, logic ill32);
    vec_t v;
    v.inst = inst; v.ill = ill; v.alu = alu; v.word = word; v.bru = bru; v.lsu = lsu;
    v.csr = csr; v.src1 = src1; v.src2 = src2; v.rfres = rfres; v.we = we; v.rd = rd;
    v.imm = imm; v.ill32 = ill32;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [63:0] pc, input logic [31:0] inst);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [63:0] pc_v;

    // addi x1,x0,-1
    vecs[0]  = mk(32'hFFF00093, 0, A_ADD, 0, 0, 0, 0, 0, 1, 0, 1, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    // addiw x2,x1,1
    vecs[1]  = mk(32'h0010811B, 0, A_ADD, 1, 0, 0, 0, 0, 1, 0, 1, 5'd2, 64'd1, 1);
    // add x0,x0,x0
    vecs[2]  = mk(32'h00000033, 0, A_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 64'd0, 0);
    // srai x5,x6,63
    vecs[3]  = mk(32'h43F35293, 0, A_SRA, 0, 0, 0, 0, 0, 1, 0, 1, 5'd5, 64'd63, 1);
    // ld x3,-8(x2)
    vecs[4]  = mk(32'hFF813183, 0, A_ADD, 0, 0, 7'b100_0010, 0, 0, 1, 2'b01, 1, 5'd3,
                  64'hFFFF_FFFF_FFFF_FFF8, 1);
    // sd x5,16(x2)
    vecs[5]  = mk(32'h00513823, 0, A_ADD, 0, 0, 7'b110_0010, 0, 0, 1, 0, 0, 5'd16, 64'd16, 1);
    // beq x1,x2,-4
    vecs[6]  = mk(32'hFE208EE3, 0, 0, 0, 8'b0010_0000, 0, 0, 0, 0, 0, 0, 5'd29,
                  64'hFFFF_FFFF_FFFF_FFFC, 0);
    // lui x10,0x80000
    vecs[7]  = mk(32'h80000537, 0, A_ADD, 0, 0, 0, 0, 2'b01, 1, 0, 1, 5'd10,
                  64'hFFFF_FFFF_8000_0000, 0);
    // jal x1,2048
    vecs[8]  = mk(32'h001000EF, 0, 0, 0, 8'b1000_0000, 0, 0, 0, 0, 2'b10, 1, 5'd1, 64'h800, 0);
    // unknown opcode
    vecs[9]  = mk(32'hFFFFFFFF, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd31, 64'd0, 1);
    // slli x1,x1,32
    vecs[10] = mk(32'h02009093, 0, A_SLL, 0, 0, 0, 0, 0, 1, 0, 1, 5'd1, 64'd32, 1);
    // ecall
    vecs[11] = mk(32'h00000073, 0, 0, 0, 0, 0, 10'b00_1000_0000, 0, 0, 0, 0, 5'd0, 64'd0, 0);
    // csrrw x1,mstatus,x2
`ifdef ZICSR_DECODE_EN
    vecs[12] = mk(32'h300110F3, 0, 0, 0, 0, 0, 10'b00_0010_0000, 0, 0, 0, 1, 5'd1, 64'd0, 0);
`else
    vecs[12] = mk(32'h300110F3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd1, 64'd0, 1);
`endif
    // sraiw with inst[25]=1
    vecs[13] = mk(32'h4200D09B, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd1, 64'd0, 1);
    // subw x3,x1,x2
    vecs[14] = mk(32'h402081BB, 0, A_SUB, 1, 0, 0, 0, 0, 0, 0, 1, 5'd3, 64'd0, 1);

    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = 32'h0; in_pc = 64'h0;
    tick(); tick();
    resetn = 1'b1;

    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_count", count, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_rf_we", out_rf_we, 0);
    check("rst32_count", s_count, 0);

    // Decode table: one push, inspect head, one pop
    for (int i = 0; i < NV; i++) begin
      pc_v = 64'hA000_0000_0000_0000 | 64'(i << 4);
      push_one(pc_v, vecs[i].inst);
      check($sformatf("v%0d_out_valid", i), out_valid, 1);
      check($sformatf("v%0d_count", i), count, 1);
      check($sformatf("v%0d_pc", i), out_pc, pc_v);
      check($sformatf("v%0d_illegal", i), out_illegal, vecs[i].ill);
      check($sformatf("v%0d_alu", i), out_alu_op, vecs[i].alu);
      check($sformatf("v%0d_word", i), out_word, vecs[i].word);
      check($sformatf("v%0d_bru", i), out_bru_op, vecs[i].bru);
      check($sformatf("v%0d_lsu", i), out_lsu_op, vecs[i].lsu);
      check($sformatf("v%0d_csr", i), out_csr_op, vecs[i].csr);
      check($sformatf("v%0d_src1", i), out_sel_src1, vecs[i].src1);
      check($sformatf("v%0d_src2", i), out_sel_src2, vecs[i].src2);
      check($sformatf("v%0d_rfres", i), out_sel_rf_res, vecs[i].rfres);
      check($sformatf("v%0d_rf_we", i), out_rf_we, vecs[i].we);
      check($sformatf("v%0d_rd", i), out_rd, vecs[i].rd);
      if (!vecs[i].ill) check($sformatf("v%0d_imm", i), out_imm, vecs[i].imm);
      check($sformatf("v%0d_illegal32", i), s_illegal, vecs[i].ill32);
      check($sformatf("v%0d_pc32", i), s_pc, pc_v[31:0]);
      if (vecs[i].ill32) check($sformatf("v%0d_rf_we32", i), s_rf_we, 0);
      else check($sformatf("v%0d_imm32", i), s_imm, vecs[i].imm[31:0]);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check($sformatf("v%0d_empty_valid", i), out_valid, 0);
      check($sformatf("v%0d_empty_imm", i), out_imm, 0);
      check($sformatf("v%0d_empty_alu", i), out_alu_op, 0);
    end

    // Fill to DEPTH with out_ready low
    for (int i = 0; i < DEPTH; i++) begin
      pc_v = 64'h1000 + 64'(i * 4);
      push_one(pc_v, 32'h00000093 | (32'(i) << 20));
      exp_q.push_back(pc_v);
    end
    check("full_count", count, 4);
    check("full_in_ready", in_ready, 0);
    push_one(64'hBAD, 32'h00000093);
    check("full_push_blocked", count, 4);

    // Make room, then six simultaneous push/pop cycles across the wrap
    out_ready = 1'b1;
    check("wrap_pre_pop", out_pc, exp_q[0]);
    tick();
    void'(exp_q.pop_front());
    for (int i = 0; i < 6; i++) begin
      pc_v = 64'h2000 + 64'(i * 4);
      in_valid = 1'b1;
      in_inst  = 32'h00000093;
      in_pc    = pc_v;
      check($sformatf("wrap%0d_head", i), out_pc, exp_q[0]);
      tick();
      void'(exp_q.pop_front());
      exp_q.push_back(pc_v);
      check($sformatf("wrap%0d_count", i), count, 3);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("drain%0d_head", i), out_pc, exp_q[0]);
      tick();
      void'(exp_q.pop_front());
    end
    out_ready = 1'b0;
    check("drain_valid", out_valid, 0);
    check("drain_count", count, 0);

    // Flush with three entries queued and a concurrent enqueue
    for (int i = 0; i < 3; i++) push_one(64'h3000 + 64'(i * 4), 32'h00000093);
    check("preflush_count", count, 3);
    flush = 1'b1;
    push_one(64'hDEAD0, 32'h00000093);
    flush = 1'b0;
    check("flush_count", count, 0);
    check("flush_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    check("flush32_count", s_count, 0);
    push_one(64'h4000, 32'h00000093);
    check("postflush_head", out_pc, 64'h4000);
    check("postflush_count", count, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("postflush_empty", count, 0);

    // Reset for one cycle with two entries queued
    push_one(64'h5000, 32'h00000093);
    push_one(64'h5004, 32'h00000093);
    check("prereset_count", count, 2);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check("midreset_count", count, 0);
    check("midreset_valid", out_valid, 0);
    check("midreset_in_ready", in_ready, 1);
    check("midreset_pc", out_pc, 0);
    push_one(64'h6000, 32'h00000093);
    check("postreset_head", out_pc, 64'h6000);
    check("postreset_count", count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning datapath width; legal values are 32 and 64.
REQ-002 SHALL have parameter DEPTH, default 4, meaning queue entries; must be a power of two and at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port resetn, input, 1 bit: synchronous active-low reset.
REQ-005 SHALL have port flush, input, 1 bit: discards all entries.
REQ-006 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_inst (input, 32) and in_pc (input, XLEN): the enqueue side.
REQ-007 SHALL have ports out_valid (output, 1) and out_ready (input, 1): the dequeue handshake.
REQ-008 SHALL have the following outputs from the head entry:
- out_pc [XLEN]
- out_rs1, out_rs2, out_rd [5 each]
- out_imm [XLEN]
- out_alu_op [10]: add, sub, sll, slt, sltu, xor, srl, sra, or, and
- out_word [1]: the op is a 32-bit W-op
- out_bru_op [8]: jal, jalr, beq, bne, blt, bge, bltu, bgeu
- out_lsu_op [7]: en, we, size one-hot byte/half/word/double, unsigned
- out_csr_op [10]: fence, fence_i, ecall, ebreak, csrrw, csrrs, csrrc, csrrwi, csrrsi, csrrci
- out_sel_src1 [2]: pc, zero
- out_sel_src2 [1]: imm
- out_sel_rf_res [2]: pc+4, load
- out_rf_we [1]
- out_illegal [1]
REQ-009 SHALL have port count, output, $clog2(DEPTH)+1 bits: current occupancy.

Function
REQ-010 SHALL decode in_inst combinationally at enqueue and store the decoded bundle plus pc; outputs SHALL be driven directly from the head entry's storage.
REQ-011 SHALL deliver first-in first-out order; an entry enqueued in cycle N into an empty queue SHALL show out_valid=1 in cycle N+1.
REQ-012 SHALL set in_ready = (count < DEPTH) and enqueue on in_valid&in_ready.
REQ-013 SHALL dequeue on out_valid&out_ready, with out_valid = (count != 0).
REQ-014 SHALL leave count unchanged on a simultaneous enqueue and dequeue.
REQ-015 SHALL wrap read and write pointers modulo DEPTH.
REQ-016 SHALL make flush take priority: the next cycle has count=0, equal pointers and out_valid=0, and any in_valid in the flush cycle is dropped.
REQ-017 SHALL decode all RV32I instructions; when XLEN=64 it SHALL also decode ADDIW/SLLIW/SRLIW/SRAIW, ADDW/SUBW/SLLW/SRLW/SRAW (out_word=1), LD, LWU and SD.
REQ-018 SHALL sign-extend I/S/B/U/J immediates to XLEN.
REQ-019 SHALL zero-extend the shift amount, using 6 bits for 64-bit shifts and 5 bits for W-shifts and XLEN=32.
REQ-020 SHALL treat shift-immediates with inst[25]=1 as illegal when XLEN=32 and for W-shifts.
REQ-021 SHALL treat 64-bit-only encodings as illegal when XLEN=32.
REQ-022 SHALL, for any unrecognised encoding, set out_illegal=1 and zero every op, select and rf_we field; the pc is kept.
REQ-023 SHALL force out_rf_we=0 when rd=x0.

Reset
REQ-024 SHALL, while resetn=0 at a clk edge, clear pointers and count, so that the next cycle has out_valid=0 and in_ready=1.
REQ-025 SHALL abandon entries when reset is asserted mid-operation; entry payload storage is not reset.
REQ-026 SHALL make all decoded outputs read 0 whenever out_valid=0.

Configuration
REQ-027 SHALL, with macro ZICSR_DECODE_EN defined, decode CSRRW/CSRRS/CSRRC/CSRRWI/CSRRSI/CSRRCI into out_csr_op, with rf_we set per REQ-023 and imm = zero-extended uimm for the I-forms.
REQ-028 SHALL, without ZICSR_DECODE_EN, tie out_csr_op[5:0] to 0 and flag those six encodings illegal; fence, fence.i, ecall and ebreak SHALL be decoded in both builds.

Structure
REQ-029 SHALL place the opcode constants, op-vector widths and the decoded-bundle struct in the shared package decode_pkg.
REQ-030 SHALL place the combinational decoding in sub-module decode_core (parameter XLEN); decode_queue holds storage, pointers and handshake.

Verification
REQ-031 SHALL cover: XLEN=64, push 0xFFF00093 (addi x1,x0,-1) into an empty queue -> next cycle out_valid=1, out_imm=0xFFFFFFFFFFFFFFFF, alu add, out_sel_src2=1, out_rd=1, out_rf_we=1.
REQ-032 SHALL cover: DEPTH=4, out_ready=0, four pushes -> count=4 and in_ready=0; then 6 push/pop pairs -> pops in order across pointer wrap.
REQ-033 SHALL cover: 0x0010811B (addiw x2,x1,1) -> with XLEN=64, out_word=1 and alu add; with XLEN=32, out_illegal=1 and out_rf_we=0.
REQ-034 SHALL cover: 3 entries queued, flush=1 together with in_valid=1 -> next cycle count=0 and out_valid=0, and the flush-cycle instruction never appears.
REQ-035 SHALL cover: 0x300110F3 (csrrw x1,mstatus,x2) -> with the macro, csrrw bit set and rf_we=1; without it, out_illegal=1.
REQ-036 SHALL cover: 0x00000033 (add x0,x0,x0) -> rf_we=0; resetn=0 for one cycle with 2 entries -> count=0 and out_valid=0.
